// File: rtl/outlier_column_mask.sv
// Purpose: ORs IN_DEPTH rows of per-column outlier flags into a sticky column mask and counts all set flags per tile.
// Latency: data_out_valid rises the cycle after the last-row handshake; one idle cycle per tile for emission.
// Backpressure: while a tile waits on data_out_ready, data_in_ready stays low and no rows are consumed.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   data_in         one row of outlier flags, bit i = column i (valid/ready handshake)
//   data_out        per-column mask of the completed tile
//   count_out       total number of flags set across the completed tile
//   data_out_valid  data_out/count_out hold a completed tile (valid/ready handshake)
module outlier_column_mask #(
  parameter  int IN_SIZE   = 4,
  parameter  int IN_DEPTH  = 8,
  localparam int CNT_WIDTH = $clog2(IN_SIZE * IN_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_SIZE-1:0]   data_in,
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic [IN_SIZE-1:0]   data_out,
  output logic [CNT_WIDTH-1:0] count_out,
  output logic                 data_out_valid,
  input  logic                 data_out_ready
);

  // A one-row tile still needs a 1-bit counter so the declaration stays legal.
  localparam int BEAT_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(IN_DEPTH - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [IN_SIZE-1:0]   mask_q, mask_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [IN_SIZE-1:0] v);
    logic [CNT_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < IN_SIZE; i++) begin
      c = c + CNT_WIDTH'(v[i]);
    end
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      beat_q  <= '0;
      mask_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      mask_q  <= mask_d;
      count_q <= count_d;
    end
  end

  // Handshake flags depend only on state, so ready never loops back through data_in.
  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    mask_d         = mask_q;
    count_d        = count_q;
    data_in_ready  = (state_q == ACCUM);
    data_out_valid = (state_q == EMIT);

    case (state_q)
      ACCUM: begin
        if (data_in_valid) begin
          mask_d  = mask_q | data_in;
          count_d = count_q + popcount(data_in);
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = EMIT;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      EMIT: begin
        // Clearing here means the next tile starts from zero without a separate flush cycle.
        if (data_out_ready) begin
          mask_d  = '0;
          count_d = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  assign data_out  = mask_q;
  assign count_out = count_q;

endmodule

// File: tb/tb_outlier_column_mask.sv
module tb_outlier_column_mask;

  localparam int IN_SIZE  = 4;
  localparam int IN_DEPTH = 8;
  localparam int CW       = $clog2(IN_SIZE * IN_DEPTH + 1);
  localparam int CW1      = $clog2(IN_SIZE * 1 + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    data_in = '0;
  logic          data_in_valid = 1'b0;
  logic          data_in_ready;
  logic [3:0]    data_out;
  logic [CW-1:0] count_out;
  logic          data_out_valid;
  logic          data_out_ready = 1'b1;

  logic           d1_data_in_valid = 1'b0;
  logic [3:0]     d1_data_in = '0;
  logic           d1_data_in_ready;
  logic [3:0]     d1_data_out;
  logic [CW1-1:0] d1_count_out;
  logic           d1_data_out_valid;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]    mask;
    logic [CW-1:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  typedef struct packed {
    logic [7:0][3:0] beats;
    logic [3:0]      mask;
    logic [CW-1:0]   cnt;
    logic [1:0]      gap;
  } vec_t;

  always #5 clk = ~clk;

  outlier_column_mask #(.IN_SIZE(IN_SIZE), .IN_DEPTH(IN_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_out(data_out), .count_out(count_out),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
  );

  outlier_column_mask #(.IN_SIZE(IN_SIZE), .IN_DEPTH(1)) dut_d1 (
    .clk(clk), .rst(rst),
    .data_in(d1_data_in), .data_in_valid(d1_data_in_valid), .data_in_ready(d1_data_in_ready),
    .data_out(d1_data_out), .count_out(d1_count_out),
    .data_out_valid(d1_data_out_valid), .data_out_ready(1'b1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every output handshake pops the oldest expected tile.
  always @(negedge clk) begin
    if (!rst && data_out_valid && data_out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tile_unexpected: got %0h/%0d, expected no tile", data_out, count_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("tile_mask", 32'(data_out), 32'(e.mask));
        check("tile_count", 32'(count_out), 32'(e.cnt));
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 right after the beat is accepted.
  task automatic send_beat(input logic [3:0] f);
    int n;
    n = 0;
    data_in       = f;
    data_in_valid = 1'b1;
    @(negedge clk);
    while (!data_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!data_in_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: data_in_ready stayed %0b, expected 1", data_in_ready);
    end
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    data_in       = 4'hF;  // junk on idle cycles must be ignored
  endtask

  task automatic send_tile(input vec_t v);
    for (int i = 0; i < IN_DEPTH; i++) begin
      repeat ($urandom_range(0, int'(v.gap))) begin
        @(posedge clk);
        #1;
      end
      if (i == IN_DEPTH - 1) exp_q.push_back('{mask: v.mask, cnt: v.cnt});
      send_beat(v.beats[i]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_count_out", 32'(count_out), 32'h0);
    check("rst_out_valid", 32'(data_out_valid), 32'h0);
    check("rst_in_ready", 32'(data_in_ready), 32'h1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 32'(exp_q.size()), 32'h0);
  endtask

  vec_t vecs[6];
  logic [3:0] d1_f[4];
  logic [2:0] d1_c[4];
  logic [3:0] hold_mask;
  logic [CW-1:0] hold_cnt;

  initial begin
    vecs[0] = '{beats: {4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0}, mask: 4'h0, cnt: 6'd0,  gap: 2'd0};
    vecs[1] = '{beats: {4'h0, 4'h0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1}, mask: 4'h9, cnt: 6'd3,  gap: 2'd0};
    vecs[2] = '{beats: {4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0}, mask: 4'h0, cnt: 6'd0,  gap: 2'd1};
    vecs[3] = '{beats: {4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF}, mask: 4'hF, cnt: 6'd32, gap: 2'd0};
    vecs[4] = '{beats: {4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h4, 4'h2, 4'h1}, mask: 4'hF, cnt: 6'd4,  gap: 2'd2};
    vecs[5] = '{beats: {4'hC, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3, 4'h3}, mask: 4'hF, cnt: 6'd6,  gap: 2'd1};

    @(posedge clk);
    #1;
    do_reset();

    // Exact one-cycle emission window after the 8th handshake.
    send_tile(vecs[0]);
    @(negedge clk);
    check("lat_valid_rise", 32'(data_out_valid), 32'h1);
    check("lat_in_ready_low", 32'(data_in_ready), 32'h0);
    @(negedge clk);
    check("lat_valid_fall", 32'(data_out_valid), 32'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) send_tile(vecs[i]);
    drain("drain_table");

    // Random valid toggling; idle cycles carry 1111 which must be ignored.
    send_tile('{beats: {8{4'h2}}, mask: 4'h2, cnt: 6'd8, gap: 2'd3});
    drain("drain_random");

    // Backpressure: tile held for 5 cycles while upstream offers data.
    data_out_ready = 1'b0;
    send_tile(vecs[1]);
    hold_mask = 4'h9;
    hold_cnt  = 6'd3;
    data_in       = 4'hF;
    data_in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", 32'(data_out_valid), 32'h1);
      check("stall_mask", 32'(data_out), 32'(hold_mask));
      check("stall_count", 32'(count_out), 32'(hold_cnt));
      check("stall_in_ready", 32'(data_in_ready), 32'h0);
    end
    @(posedge clk);
    #1;
    data_in_valid  = 1'b0;
    data_out_ready = 1'b1;
    drain("drain_stall");
    send_tile('{beats: {4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4}, mask: 4'h4, cnt: 6'd1, gap: 2'd0});
    drain("drain_after_stall");

    // Reset mid-tile discards the partial rows.
    for (int i = 0; i < 3; i++) send_beat(4'hF);
    do_reset();
    send_tile('{beats: {8{4'h4}}, mask: 4'h4, cnt: 6'd8, gap: 2'd0});
    drain("drain_mid_reset");

    // Reset while a tile is pending discards it.
    data_out_ready = 1'b0;
    send_tile(vecs[3]);
    @(negedge clk);
    check("pend_valid", 32'(data_out_valid), 32'h1);
    @(posedge clk);
    #1;
    do_reset();
    data_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("pend_dropped", 32'(data_out_valid), 32'h0);
    @(posedge clk);
    #1;

    // IN_DEPTH=1: every row is its own tile.
    d1_f = '{4'h5, 4'hA, 4'hF, 4'h0};
    d1_c = '{3'd2, 3'd2, 3'd4, 3'd0};
    for (int i = 0; i < 4; i++) begin
      d1_data_in       = d1_f[i];
      d1_data_in_valid = 1'b1;
      @(negedge clk);
      check("d1_in_ready", 32'(d1_data_in_ready), 32'h1);
      @(posedge clk);
      #1;
      d1_data_in_valid = 1'b0;
      d1_data_in       = 4'hF;
      @(negedge clk);
      check("d1_valid", 32'(d1_data_out_valid), 32'h1);
      check("d1_mask", 32'(d1_data_out), 32'(d1_f[i]));
      check("d1_count", 32'(d1_count_out), 32'(d1_c[i]));
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
